// File: rtl/log_dot_pkg.sv
// log_dot_pkg: shared types and helpers for the log-domain dot-product sequencer.
//   state_t    : sequencer FSM states (S_ACC, S_FLUSH, S_OUT)
//   esum_t     : width used for the exponent sum exp_a+exp_b (wide enough that it never wraps)
//   min_acc_w  : smallest accumulator width that holds one full-range term plus its sign
package log_dot_pkg;

  typedef enum logic [1:0] {
    S_ACC   = 2'd0,
    S_FLUSH = 2'd1,
    S_OUT   = 2'd2
  } state_t;

  // Exponent fields up to 15 bits each sum without wrap in 16 bits.
  localparam int ESUM_W = 16;
  typedef logic [ESUM_W-1:0] esum_t;

  // Largest term is 2**((2**ea-1)+(2**eb-1)); one more bit for the sign,
  // one more so the negated magnitude is representable.
  function automatic int min_acc_w(input int ea, input int eb);
    return ((1 << ea) - 1) + ((1 << eb) - 1) + 2;
  endfunction

endpackage

// File: rtl/log_dot_sequencer_if.sv
// log_dot_sequencer_if: operand stream in, result stream out, for one log-domain dot product.
//   in_valid/in_ready/in_a/in_b/in_last : operand pairs, {sign, exp} each, last marks end of vector
//   out_valid/out_ready                  : result handshake
//   out_acc                              : exact signed sum of terms (ACC_W bits, modular)
//   out_count                            : pairs accepted for this vector (saturating)
//   out_ovf                              : sticky signed overflow, present only with LOG_DOT_OVF_EN
// Modports: master = stream source / result consumer, slave = sequencer.
interface log_dot_sequencer_if #(
  parameter int EXP_A = 3,
  parameter int EXP_B = 3,
  parameter int ACC_W = 32,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [EXP_A:0]   in_a;
  logic [EXP_B:0]   in_b;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_acc;
  logic [CNT_W-1:0] out_count;
`ifdef LOG_DOT_OVF_EN
  logic             out_ovf;
`endif

  modport master (
    output in_valid, in_a, in_b, in_last, out_ready,
    input  in_ready, out_valid, out_acc, out_count
`ifdef LOG_DOT_OVF_EN
    , input out_ovf
`endif
  );

  modport slave (
    input  in_valid, in_a, in_b, in_last, out_ready,
    output in_ready, out_valid, out_acc, out_count
`ifdef LOG_DOT_OVF_EN
    , output out_ovf
`endif
  );
endinterface

// File: rtl/log_term_decode.sv
// log_term_decode: combinational decode of one log-domain operand pair into a
// signed power-of-two Kulisch term.
//   a_i    : {sign, exp} of operand a (EXP_A+1 bits)
//   b_i    : {sign, exp} of operand b (EXP_B+1 bits)
//   term_o : (sign_a ^ sign_b) ? -(2**(exp_a+exp_b)) : +(2**(exp_a+exp_b)), ACC_W bits signed
module log_term_decode
  import log_dot_pkg::*;
#(
  parameter int EXP_A = 3,
  parameter int EXP_B = 3,
  parameter int ACC_W = 32
) (
  input  logic [EXP_A:0]           a_i,
  input  logic [EXP_B:0]           b_i,
  output logic signed [ACC_W-1:0] term_o
);

  esum_t                   e;
  logic                    s;
  logic signed [ACC_W-1:0] mag;

  always_comb begin
    e      = esum_t'(a_i[EXP_A-1:0]) + esum_t'(b_i[EXP_B-1:0]);
    s      = a_i[EXP_A] ^ b_i[EXP_B];
    mag    = ACC_W'(1) << e;
    term_o = s ? -mag : mag;
  end

endmodule

// File: rtl/log_dot_sequencer.sv
// log_dot_sequencer: sequences one log-domain dot product.
// Accepts (a,b) pairs, decodes each into a power-of-two term, registers the term
// (stage p0) and adds it into the accumulator one cycle later. On the last pair
// the pipeline drains (S_FLUSH) and the sum is offered until taken (S_OUT), after
// which accumulator, count and overflow flag clear for the next vector.
// Ports:
//   clock : clock
//   reset : synchronous, active-high; discards in-flight term, acc and count
//   bus   : log_dot_sequencer_if.slave (operand stream in, result out)
// Optional feature: define LOG_DOT_OVF_EN for the sticky out_ovf flag.
module log_dot_sequencer
  import log_dot_pkg::*;
#(
  parameter int EXP_A = 3,
  parameter int EXP_B = 3,
  parameter int ACC_W = 32,
  parameter int CNT_W = 16
) (
  input logic                 clock,
  input logic                 reset,
  log_dot_sequencer_if.slave  bus
);

  if (ACC_W < min_acc_w(EXP_A, EXP_B)) begin : g_acc_w_chk
    $error("log_dot_sequencer: ACC_W too narrow for EXP_A/EXP_B");
  end

  state_t                  state_q, state_d;
  logic                    accept;
  logic                    clear;
  logic signed [ACC_W-1:0] term_dec;
  logic signed [ACC_W-1:0] term_p0_q;
  logic                    vld_p0_q;
  logic signed [ACC_W-1:0] acc_sum;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  assign bus.in_ready  = (state_q == S_ACC) && !reset;
  assign bus.out_valid = (state_q == S_OUT) && !reset;
  assign bus.out_acc   = acc_q;
  assign bus.out_count = cnt_q;

  assign accept = bus.in_valid && bus.in_ready;
  assign clear  = (state_q == S_OUT) && bus.out_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_ACC:   if (accept && bus.in_last) state_d = S_FLUSH;
      S_FLUSH: state_d = S_OUT;
      S_OUT:   if (bus.out_ready) state_d = S_ACC;
      default: state_d = S_ACC;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state_q <= S_ACC;
    else       state_q <= state_d;
  end

  log_term_decode #(
    .EXP_A (EXP_A),
    .EXP_B (EXP_B),
    .ACC_W (ACC_W)
  ) u_decode (
    .a_i    (bus.in_a),
    .b_i    (bus.in_b),
    .term_o (term_dec)
  );

  // ---- stage p0: decoded term register ----
  always_ff @(posedge clock) begin
    if (accept) term_p0_q <= term_dec;
  end

  always_ff @(posedge clock) begin
    if (reset) vld_p0_q <= 1'b0;
    else       vld_p0_q <= accept;
  end

  // ---- stage p1: accumulate and count ----
  // No accept happens in S_FLUSH, so the term stage is always empty in S_OUT
  // and clear never collides with a retiring term.
  assign acc_sum = acc_q + term_p0_q;

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (clear) begin
      acc_d = '0;
      cnt_d = '0;
    end else begin
      if (vld_p0_q) acc_d = acc_sum;
      if (accept)   cnt_d = sat_inc(cnt_q);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

`ifdef LOG_DOT_OVF_EN
  logic ovf_q, ovf_d;

  // Signed overflow: operands agree in sign, result sign differs.
  always_comb begin
    ovf_d = ovf_q;
    if (clear) ovf_d = 1'b0;
    else if (vld_p0_q && (acc_q[ACC_W-1] == term_p0_q[ACC_W-1]) &&
             (acc_sum[ACC_W-1] != acc_q[ACC_W-1]))
      ovf_d = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) ovf_q <= 1'b0;
    else       ovf_q <= ovf_d;
  end

  assign bus.out_ovf = ovf_q;
`endif

endmodule
